// File: rtl/bus_gnt.sv
// bus_gnt: pops ready brq entries and owns the shared bus for a fixed transfer window per entry.
// Ports: clk/clr clock and sync reset; req_ready/send_in/dest_in are the brq head.
// hold blocks new pulls; done ends a transfer early when BUS_GNT_DONE_EN is defined.
// Outputs: pull pops brq; grant/recv are one-hot sender/destination enables.
// cur_send/cur_dest are the latched IDs; bus_busy is set in XFER and GAP; err pulses once per dropped illegal request.
// Optional macro: BUS_GNT_DONE_EN (done ends XFER early, XFER_CYCLES becomes a timeout).
module bus_gnt #(
  parameter int          XFER_CYCLES = 4,
  parameter int          GAP_CYCLES  = 1,
  parameter logic [15:0] VALID_MASK  = 16'h1FF3
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        req_ready,
  input  logic [3:0]  send_in,
  input  logic [3:0]  dest_in,
  input  logic        hold,
  input  logic        done,
  output logic        pull,
  output logic [15:0] grant,
  output logic [15:0] recv,
  output logic [3:0]  cur_send,
  output logic [3:0]  cur_dest,
  output logic        bus_busy,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;
  state_t     r_state, w_state_nx;
  logic [7:0] r_cnt, w_cnt_nx;
  logic [3:0] r_gcnt, w_gcnt_nx;
  logic [3:0] r_send, r_dest;
  logic       r_err, w_err_nx, w_legal, w_end;
  assign w_legal = VALID_MASK[send_in] & VALID_MASK[dest_in] & (send_in != dest_in);
`ifdef BUS_GNT_DONE_EN
  assign w_end = (r_cnt == 8'd0) | done;
`else
  assign w_end = (r_cnt == 8'd0) | (done & 1'b0);
`endif
  assign pull     = (r_state == IDLE) & req_ready & ~hold & ~clr;
  assign grant    = (r_state == XFER) ? 16'd1 << r_send : 16'd0;
  assign recv     = (r_state == XFER) ? 16'd1 << r_dest : 16'd0;
  assign bus_busy = r_state != IDLE;
  assign cur_send = r_send;
  assign cur_dest = r_dest;
  assign err      = r_err;
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_gcnt_nx  = r_gcnt;
    w_err_nx   = 1'b0;
    case (r_state)
      IDLE: if (pull) begin
        // illegal entries are still popped, only flagged
        w_state_nx = w_legal ? XFER : IDLE;
        w_cnt_nx   = 8'(XFER_CYCLES - 1);
        w_err_nx   = ~w_legal;
      end
      XFER: if (w_end) begin
        w_state_nx = (GAP_CYCLES == 0) ? IDLE : GAP;
        w_gcnt_nx  = 4'(GAP_CYCLES - 1);
      end else w_cnt_nx = r_cnt - 8'd1;
      GAP: if (r_gcnt == 4'd0) w_state_nx = IDLE;
        else w_gcnt_nx = r_gcnt - 4'd1;
      default: w_state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_gcnt  <= '0;
      r_send  <= '0;
      r_dest  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_gcnt  <= w_gcnt_nx;
      r_err   <= w_err_nx;
      if (pull) begin
        r_send <= send_in;
        r_dest <= dest_in;
      end
    end
  end
endmodule

// File: tb/tb_bus_gnt.sv
// tb_bus_gnt: directed checks of bus_gnt with default parameters.
module tb_bus_gnt;
  logic        clk = 1'b0, clr, req_ready, hold, done;
  logic [3:0]  send_in, dest_in, cur_send, cur_dest;
  logic        pull, bus_busy, err;
  logic [15:0] grant, recv;
  int          n_chk = 0, n_err = 0;
  logic [3:0]  q_s [4], q_d [4];
  always #5 clk = ~clk;
  bus_gnt dut (
    .clk(clk), .clr(clr), .req_ready(req_ready), .send_in(send_in), .dest_in(dest_in),
    .hold(hold), .done(done), .pull(pull), .grant(grant), .recv(recv),
    .cur_send(cur_send), .cur_dest(cur_dest), .bus_busy(bus_busy), .err(err)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run_seq(input int n, input int cycles);
    int idx = 0;
    for (int k = 0; k < cycles; k++) begin
      req_ready = idx < n;
      send_in   = q_s[idx % 4];
      dest_in   = q_d[idx % 4];
      @(negedge clk);
      chk($sformatf("seq pull c%0d", k), pull, (k % 6 == 0) && (k / 6 < n));
      chk($sformatf("seq busy c%0d", k), bus_busy, (k % 6 != 0) && (k / 6 < n));
      chk($sformatf("seq grant c%0d", k), grant,
          (k % 6 >= 1 && k % 6 <= 4 && k / 6 < n) ? 16'h1 << q_s[(k / 6) % 4] : 16'h0);
      chk($sformatf("seq recv c%0d", k), recv,
          (k % 6 >= 1 && k % 6 <= 4 && k / 6 < n) ? 16'h1 << q_d[(k / 6) % 4] : 16'h0);
      if (k % 6 == 1 && k / 6 < n) begin
        chk("seq cur_send", cur_send, q_s[(k / 6) % 4]);
        chk("seq cur_dest", cur_dest, q_d[(k / 6) % 4]);
      end
      if (k % 6 == 0 && k / 6 < n) idx++;
      step();
    end
    req_ready = 1'b0;
  endtask
  initial begin
    int gcount;
    clr = 1'b1; req_ready = 1'b0; hold = 1'b0; done = 1'b0; send_in = 4'h0; dest_in = 4'h0;
    step(); step();
    clr = 1'b1;
    @(negedge clk);
    chk("rst grant", grant, 16'h0);
    chk("rst recv", recv, 16'h0);
    chk("rst busy", bus_busy, 1'b0);
    chk("rst err", err, 1'b0);
    chk("rst cur", {cur_send, cur_dest}, 8'h00);
    chk("rst pull", pull, 1'b0);
    step();
    clr = 1'b0;
    q_s[0] = 4'hc; q_d[0] = 4'h0; q_s[1] = 4'hc; q_d[1] = 4'h0;
    run_seq(2, 13);
    q_s[0] = 4'h9; q_d[0] = 4'h5;
    q_s[1] = 4'h1; q_d[1] = 4'h8;
    q_s[2] = 4'h4; q_d[2] = 4'ha;
    run_seq(3, 19);
    req_ready = 1'b1; send_in = 4'h2; dest_in = 4'h0;
    @(negedge clk);
    chk("ill0 pull", pull, 1'b1);
    step();
    send_in = 4'h5; dest_in = 4'h5;
    @(negedge clk);
    chk("ill0 err", err, 1'b1);
    chk("ill0 grant", grant, 16'h0);
    chk("ill0 busy", bus_busy, 1'b0);
    chk("ill1 pull", pull, 1'b1);
    step();
    send_in = 4'h9; dest_in = 4'h5;
    @(negedge clk);
    chk("ill1 err", err, 1'b1);
    chk("ill1 recv", recv, 16'h0);
    chk("ill1 busy", bus_busy, 1'b0);
    chk("legal pull", pull, 1'b1);
    step();
    req_ready = 1'b0;
    @(negedge clk);
    chk("legal err", err, 1'b0);
    chk("legal grant", grant, 16'h0200);
    chk("legal recv", recv, 16'h0020);
    repeat (6) step();
    hold = 1'b1; req_ready = 1'b1; send_in = 4'hc; dest_in = 4'h1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("hold pull c%0d", k), pull, 1'b0);
      chk($sformatf("hold busy c%0d", k), bus_busy, 1'b0);
      step();
    end
    hold = 1'b0;
    @(negedge clk);
    chk("unhold pull", pull, 1'b1);
    step();
    req_ready = 1'b0;
    @(negedge clk);
    chk("unhold grant", grant, 16'h1000);
    chk("unhold recv", recv, 16'h0002);
    repeat (6) step();
    req_ready = 1'b1; send_in = 4'hc; dest_in = 4'h0;
    step();
    req_ready = 1'b0;
    step();
    clr = 1'b1;
    @(negedge clk);
    chk("clr xfer grant", grant, 16'h1000);
    chk("clr pull", pull, 1'b0);
    step();
    clr = 1'b0; req_ready = 1'b1; send_in = 4'h4; dest_in = 4'h5;
    @(negedge clk);
    chk("clr grant", grant, 16'h0);
    chk("clr recv", recv, 16'h0);
    chk("clr busy", bus_busy, 1'b0);
    chk("clr cur", {cur_send, cur_dest}, 8'h00);
    chk("clr err", err, 1'b0);
    chk("post clr pull", pull, 1'b1);
    step();
    req_ready = 1'b0;
    @(negedge clk);
    chk("post clr grant", grant, 16'h0010);
    repeat (6) step();
    done = 1'b1;
    @(negedge clk);
    chk("done idle busy", bus_busy, 1'b0);
    step();
    done = 1'b0; req_ready = 1'b1; send_in = 4'h9; dest_in = 4'h5;
    step();
    req_ready = 1'b0;
    gcount = 0;
    for (int k = 1; k <= 8; k++) begin
      done = (k == 3);
      @(negedge clk);
      if (grant != 16'h0) gcount++;
      step();
    end
    done = 1'b0;
`ifdef BUS_GNT_DONE_EN
    chk("done grant len", gcount, 3);
`else
    chk("done grant len", gcount, 4);
`endif
    @(negedge clk);
    chk("end busy", bus_busy, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
